// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: shared core constants and the fetch-buffer entry type.
package instr_fetch_stage_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;
    localparam fetch_entry_t BUBBLE = '{instr: NOP, pc4: '0};
endpackage

// File: rtl/instr_fetch_stage_fetch_fifo.sv
// fetch_fifo: 2-entry buffer of {instr, pc+4} holding fetched words across decode stalls.
module fetch_fifo
    import instr_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [2*XLEN-1:0] din,
    output logic [1:0]        count,
    output logic [2*XLEN-1:0] head
);
    logic [2*XLEN-1:0] mem [2];
    logic wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else if (clear) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else begin
            wp <= wp ^ push;
            rp <= rp ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wp] <= din;
    end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, instruction-memory requests, stall buffering and the IF/ID register.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            ID_stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_Instruction,
    output logic [XLEN-1:0] IF_ID_PCPlus4,
    output logic            IF_ID_Valid
);
    logic [XLEN-1:0] pc, tag_pc;
    logic outstanding, squash;
    logic redirect_eff, accept, resp_v, push, pop, valid_next;
    logic [1:0] count, eff_count;
    fetch_entry_t head, resp, if_next;

    fetch_fifo u_fifo (
        .clk(Clk), .rst_n(Rst), .push(push), .pop(pop), .clear(redirect_eff),
        .din(resp), .count(count), .head(head)
    );

    // A redirect sees the FIFO as already cleared, so the target can be requested at once.
    always_comb begin
        redirect_eff = redirect & ~ID_stall;
        eff_count = redirect_eff ? 2'd0 : count;
        imem_req = (eff_count == 2'd0) | ((eff_count == 2'd1) & ~outstanding);
        imem_addr = redirect_eff ? {redirect_target[XLEN-1:2], 2'b00} : pc;
        accept = imem_req & imem_gnt;
        resp_v = outstanding & ~squash & ~redirect_eff;
        resp = '{instr: imem_rdata, pc4: tag_pc + 32'd4};
        pop = ~ID_stall & ~redirect_eff & (count != 2'd0);
        push = resp_v & ~((count == 2'd0) & ~ID_stall);
        if_next = redirect_eff ? BUBBLE : (count != 2'd0) ? head : resp_v ? resp : BUBBLE;
        valid_next = ~redirect_eff & ((count != 2'd0) | resp_v);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc <= RESET_PC;
            tag_pc <= '0;
            outstanding <= 1'b0;
            squash <= 1'b0;
            IF_ID_Valid <= 1'b0;
            IF_ID_Instruction <= NOP;
            IF_ID_PCPlus4 <= '0;
        end else begin
            pc <= accept ? imem_addr + 32'd4 : imem_addr;
            tag_pc <= accept ? imem_addr : tag_pc;
            outstanding <= accept;
            squash <= redirect_eff & ~accept;
            if (!ID_stall) begin
                IF_ID_Valid <= valid_next;
                IF_ID_Instruction <= if_next.instr;
                IF_ID_PCPlus4 <= if_next.pc4;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed and random checks of the fetch stage against a stream-level model.
module tb_instr_fetch_stage;
    logic Clk, Rst, ID_stall, redirect, imem_gnt, imem_req, IF_ID_Valid;
    logic [31:0] redirect_target, imem_addr, imem_rdata, IF_ID_Instruction, IF_ID_PCPlus4;
    int n_chk = 0, n_err = 0;
    // Model: exp_pc is the next instruction decode must consume, fa the next fetch address.
    logic [31:0] exp_pc, fa, c_i, c_p, c_e, c_ea, r_addr, last_addr;
    logic c_v, r_req, last_acc;

    instr_fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .ID_stall(ID_stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rdata(imem_rdata), .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        exp_pc = 32'h0;
        fa = 32'h0;
        last_acc = 1'b0;
        last_addr = 32'h0;
    endtask

    // One clock: decode consumes / redirects, memory answers the previous accept with word == address.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tg, input logic g);
        c_v = IF_ID_Valid & ~st;
        c_i = IF_ID_Instruction;
        c_p = IF_ID_PCPlus4;
        c_e = exp_pc;
        if (c_v) exp_pc = exp_pc + 32'd4;
        if (rd && !st) exp_pc = {tg[31:2], 2'b00};
        c_ea = (rd && !st) ? {tg[31:2], 2'b00} : fa;
        ID_stall = st;
        redirect = rd;
        redirect_target = tg;
        imem_gnt = g;
        imem_rdata = last_acc ? last_addr : $urandom;
        #1;
        r_req = imem_req;
        r_addr = imem_addr;
        fa = (r_req && g) ? c_ea + 32'd4 : c_ea;
        @(posedge Clk);
        #1;
        last_acc = r_req & g;
        last_addr = r_addr;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        ID_stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        imem_gnt = 1'b1;
        imem_rdata = 32'h0;
        model_reset();
        #2;
        n_chk += 4;
        if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", IF_ID_Valid); end
        if (IF_ID_Instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", IF_ID_Instruction); end
        if (IF_ID_PCPlus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h want 0", IF_ID_PCPlus4); end
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_req got %b/%h want 1/0", imem_req, imem_addr); end
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    task automatic test_startup();
        cycle(0, 0, 0, 1);
        n_chk++;
        if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL startup_c1 valid got %0b want 0", IF_ID_Valid); end
        cycle(0, 0, 0, 1);
        n_chk++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== 32'h0 || IF_ID_PCPlus4 !== 32'h4) begin
            n_err++; $display("FAIL startup_first got %b/%h/%h want 1/0/4", IF_ID_Valid, IF_ID_Instruction, IF_ID_PCPlus4);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            n_chk += 2;
            if (!c_v || c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL startup_stream got %b/%h/%h want 1/%h", c_v, c_i, c_p, c_e); end
            if (r_addr !== c_ea) begin n_err++; $display("FAIL startup_addr got %h want %h", r_addr, c_ea); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 1);
            n_chk += 2;
            if (IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== exp_pc) begin n_err++; $display("FAIL stall_hold got %b/%h want 1/%h", IF_ID_Valid, IF_ID_Instruction, exp_pc); end
            if (r_addr !== c_ea) begin n_err++; $display("FAIL stall_addr got %h want %h", r_addr, c_ea); end
            if (k > 0) begin
                n_chk++;
                if (r_req !== 1'b0) begin n_err++; $display("FAIL stall_req got %b want 0", r_req); end
            end
        end
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 1);
            n_chk += 2;
            if (!c_v || c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL stall_stream got %b/%h/%h want 1/%h", c_v, c_i, c_p, c_e); end
            if (r_addr !== c_ea) begin n_err++; $display("FAIL stall_rel_addr got %h want %h", r_addr, c_ea); end
        end
    endtask

    task automatic test_redirect();
        cycle(0, 1, 32'h100, 1);
        n_chk += 2;
        if (r_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", r_addr); end
        if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble got %b want 0", IF_ID_Valid); end
        cycle(0, 0, 0, 1);
        n_chk++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== 32'h100 || IF_ID_PCPlus4 !== 32'h104) begin
            n_err++; $display("FAIL redir_target got %b/%h/%h want 1/100/104", IF_ID_Valid, IF_ID_Instruction, IF_ID_PCPlus4);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            n_chk++;
            if (!c_v || c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL redir_stream got %b/%h/%h want 1/%h", c_v, c_i, c_p, c_e); end
        end
    endtask

    task automatic test_redirect_stalled();
        cycle(1, 1, 32'h200, 1);
        n_chk += 2;
        if (r_addr !== c_ea) begin n_err++; $display("FAIL rstall_addr got %h want %h", r_addr, c_ea); end
        if (IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== exp_pc) begin n_err++; $display("FAIL rstall_hold got %b/%h want 1/%h", IF_ID_Valid, IF_ID_Instruction, exp_pc); end
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 1);
            n_chk++;
            if (!c_v || c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL rstall_stream got %b/%h/%h want 1/%h", c_v, c_i, c_p, c_e); end
        end
    endtask

    task automatic test_gnt_toggle();
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, (k % 2) == 0);
            n_chk++;
            if (r_addr !== c_ea) begin n_err++; $display("FAIL toggle_addr got %h want %h", r_addr, c_ea); end
            if (c_v) begin
                n_chk++;
                if (c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL toggle_stream got %h/%h want %h", c_i, c_p, c_e); end
            end
            if (k > 0) begin
                n_chk++;
                if (IF_ID_Valid !== logic'(k % 2)) begin n_err++; $display("FAIL toggle_valid k=%0d got %b want %0d", k, IF_ID_Valid, k % 2); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 1);
        Rst = 1'b0;
        imem_rdata = last_addr;
        #1;
        n_chk += 2;
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h0 || IF_ID_PCPlus4 !== 32'h0) begin
            n_err++; $display("FAIL rmid_out got %b/%h/%h want 0/0/0", IF_ID_Valid, IF_ID_Instruction, IF_ID_PCPlus4);
        end
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_req got %b/%h want 1/0", imem_req, imem_addr); end
        @(posedge Clk);
        #1;
        n_chk++;
        if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rmid_late got %b want 0", IF_ID_Valid); end
        Rst = 1'b1;
        model_reset();
        cycle(0, 0, 0, 1);
        n_chk++;
        if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rmid_c1 got %b want 0", IF_ID_Valid); end
        cycle(0, 0, 0, 1);
        n_chk++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== 32'h0 || IF_ID_PCPlus4 !== 32'h4) begin
            n_err++; $display("FAIL rmid_first got %b/%h/%h want 1/0/4", IF_ID_Valid, IF_ID_Instruction, IF_ID_PCPlus4);
        end
    endtask

    task automatic test_random();
        int consumed = 0;
        logic st, rd, g;
        logic [31:0] tg;
        cycle(0, 1, 32'hFFFF_FFF0, 1);
        for (int k = 0; k < 400; k++) begin
            st = ($urandom % 4) == 0;
            rd = ($urandom % 12) == 0;
            g = ($urandom % 4) != 0;
            tg = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            cycle(st, rd, tg, g);
            n_chk++;
            if (r_addr !== c_ea) begin n_err++; $display("FAIL rand_addr k=%0d got %h want %h", k, r_addr, c_ea); end
            if (c_v) begin
                consumed++;
                n_chk++;
                if (c_i !== c_e || c_p !== c_e + 32'd4) begin n_err++; $display("FAIL rand_stream k=%0d got %h/%h want %h", k, c_i, c_p, c_e); end
            end
            if (rd && !st) begin
                n_chk++;
                if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rand_bubble k=%0d got %b want 0", k, IF_ID_Valid); end
            end
        end
        n_chk++;
        if (consumed < 80) begin n_err++; $display("FAIL rand_progress got %0d want >=80", consumed); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_stalled();
        test_gnt_toggle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for each MIPS32 core. Holds the PC, issues word requests to the shared instruction-memory arbiter, and buffers returned words across decode stalls. Presents one instruction per cycle to the decode stage's control/hazard unit, and applies taken-branch and jump redirects resolved in decode.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- Clk  in  1  core clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ID_stall  in  1  decode hazard stall; IF/ID must hold its contents.
- redirect  in  1  taken branch, J, JAL or JR resolved in decode this cycle.
- redirect_target  in  32  new PC, valid when redirect=1.
- imem_req  out  1  fetch request to the instruction-memory arbiter.
- imem_addr  out  32  word address of the request; bits [1:0] are always 0.
- imem_gnt  in  1  arbiter accept; a transaction completes when imem_req & imem_gnt.
- imem_rdata  in  32  instruction word, valid exactly 1 cycle after the accept.
- IF_ID_Instruction  out  32  instruction to decode; 0 (NOP) when not valid.
- IF_ID_PCPlus4  out  32  PC+4 of that instruction; 0 when not valid.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.

## Operation
- Registered state:
  - pc.
  - outstanding: an accept happened last cycle.
  - squash: drop the current response.
  - tag_pc: PC of the outstanding request.
  - 2-entry FIFO of {instr, pc+4}.
  - IF/ID register.
- Request gating: imem_req = (fifo_count==0) | (fifo_count==1 & ~outstanding). This gating guarantees the FIFO never overflows.
- imem_addr = redirect_eff ? redirect_target : pc.
  - redirect_eff = redirect & ~ID_stall. A redirect with ID_stall set is ignored, because decode re-presents it next cycle.
- On accept: pc <= imem_addr + 4; tag_pc <= imem_addr; outstanding <= 1. With no accept, outstanding <= 0 and pc holds, except when redirect_eff is set, which forces pc <= redirect_target.
- A response arriving with squash=1 is discarded.
- The cycle after a response arrives, it goes to IF/ID directly when the FIFO is empty and ~ID_stall. Otherwise it is pushed into the FIFO.
- IF/ID update when ~ID_stall:
  - load the FIFO head (pop) if the FIFO is non-empty;
  - else load the arriving unsquashed response;
  - else load a bubble (Valid=0, Instruction=0, PCPlus4=0).
- IF/ID update when ID_stall: hold all three outputs. The FIFO may still push.
- Redirect, when redirect_eff is set:
  - IF/ID becomes a bubble;
  - the FIFO is cleared;
  - a response arriving this cycle is dropped;
  - squash <= 0, because the request accepted this cycle carries the target.
- There is no branch delay slot. Instructions fetched after a redirecting instruction are discarded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - pc = RESET_PC;
  - outstanding, squash and fifo_count = 0;
  - IF_ID_Valid = 0, IF_ID_Instruction = 0, IF_ID_PCPlus4 = 0;
  - imem_req = 1 combinationally (the FIFO is empty).
- Reset asserted mid-transaction: state clears immediately. The response that follows is ignored because outstanding = 0.
- Latency: an accept in cycle t places the instruction in IF/ID at the edge ending cycle t+1, so it is visible to decode in cycle t+2.
- Throughput: 1 instruction/cycle with continuous grant.
- Redirect penalty: 1 bubble in decode.
- Grant denied: the request and address hold; pc does not advance.
- Redirect together with a full FIFO: the clear wins and the request is allowed the same cycle, using post-clear occupancy.
- All outputs except imem_req and imem_addr are registered.

## Structure
- Shared core package holds RESET_PC default, NOP encoding (32'h0), and the instruction word width.
- Sub-module fetch_fifo: 2-entry, 64-bit {instr, pc+4}, with ports push, pop, clear, count, head.

## Test plan
- Reset release, grant always 1, ROM word at addr a = a → IF_ID_Valid first rises 2 cycles after release, with Instruction 0x0000_0000 then 0x0000_0004, PCPlus4 4, 8, 12…
- ID_stall held for 3 cycles mid-stream → IF/ID frozen; FIFO reaches 2; imem_req drops. After release, instructions continue with no loss or duplication.
- redirect=1, target 0x100, while a response is outstanding → one bubble, then IF/ID = word 0x100, PCPlus4 0x104; the stale word never appears.
- redirect together with ID_stall → ignored; pc and IF/ID unchanged.
- imem_gnt toggling 1-0-1-0 → imem_addr holds while denied; IF_ID_Valid alternates; the sequence stays contiguous.
- Reset asserted the cycle after an accept → all outputs at reset values; the late rdata is not captured.
